uart_rx: RTL and testbench

//   UART receiver, 8N1, LSB first. Counterpart of the SoC's UART transmitter.

---
 rtl/uart_rx_if.sv | 16 +
 rtl/uart_rx.sv | 135 +++++++++++++
 tb/tb_uart_rx.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Core-side byte handshake of the UART receiver: data, data_ready, data_read.
// frame_err is present only when UART_RX_FRAMING_ERR_EN is defined.
interface uart_rx_if;
  logic [7:0] data;
  logic       data_ready;
  logic       data_read;
`ifdef UART_RX_FRAMING_ERR_EN
  logic       frame_err;

  modport slave  (output data, output data_ready, output frame_err, input data_read);
  modport master (input data, input data_ready, input frame_err, output data_read);
`else
  modport slave  (output data, output data_ready, input data_read);
  modport master (input data, input data_ready, output data_read);
`endif
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, holding one byte behind a ready/read handshake.
// Optional stop-bit error flag and byte discard: define UART_RX_FRAMING_ERR_EN.
module uart_rx #(
  parameter int CLK_FREQ  = 66_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rx,
  uart_rx_if.slave bus
);

  localparam int BIT_TIME  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_TIME = BIT_TIME / 2;
  localparam int CNT_W     = $clog2(BIT_TIME);

  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(BIT_TIME - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_TIME - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  logic             rx_meta;
  logic             rx_s;
  logic [2:0]       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [7:0]       data_q;
  logic             data_ready_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_FRAMING_ERR_EN
  logic frame_err_q;
  assign bus.frame_err = frame_err_q;
`endif

  assign bus.data       = data_q;
  assign bus.data_ready = data_ready_q;

  // A byte completing later in this block overrides the read clear, so the new byte wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      data_q       <= '0;
      data_ready_q <= 1'b0;
`ifdef UART_RX_FRAMING_ERR_EN
      frame_err_q  <= 1'b0;
`endif
    end else begin
      if (bus.data_read) begin
        data_ready_q <= 1'b0;
`ifdef UART_RX_FRAMING_ERR_EN
        frame_err_q  <= 1'b0;
`endif
      end
      case (state)
        IDLE: begin
          if (!rx_s) begin
            bit_cnt <= HALF_RELOAD;
            state   <= START;
          end
        end
        START: begin
          if (bit_cnt == '0) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              bit_cnt <= BIT_RELOAD;
              bit_idx <= '0;
              state   <= DATA;
            end
          end else begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_cnt == '0) begin
            shift[bit_idx] <= rx_s;
            bit_cnt        <= BIT_RELOAD;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_cnt == '0) begin
            if (rx_s) begin
              data_q       <= shift;
              data_ready_q <= 1'b1;
              state        <= IDLE;
            end else begin
`ifdef UART_RX_FRAMING_ERR_EN
              frame_err_q  <= 1'b1;
`else
              data_q       <= shift;
              data_ready_q <= 1'b1;
`endif
              // A low stop bit may be a break; wait for the line to idle first.
              state <= WAIT_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BIT_TIME=2: frames, overrun, glitch, bad stop,
// async reset mid-frame and read/complete collision.
module tb_uart_rx;

  localparam int CLK_FREQ  = 50_000_000;
  localparam int BAUD_RATE = 25_000_000;
  localparam int BIT_TIME  = 2;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  int   check_count = 0;
  int   error_count = 0;

  uart_rx_if bus();

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drives start, 8 data bits LSB first and the given stop bit; returns after
  // the 20th rising edge of the frame, leaving rx at the stop-bit level.
  task automatic applyStimulus(input logic [7:0] value, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, value, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (BIT_TIME) @(negedge clk);
    end
  endtask

  task automatic readPulse();
    bus.data_read = 1'b1;
    @(negedge clk);
    bus.data_read = 1'b0;
  endtask

  initial begin
    logic [4:0] partial;
    rx            = 1'b1;
    bus.data_read = 1'b0;
    rst           = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_data", bus.data, 8'h00);
    checkOutput("reset_ready", 8'(bus.data_ready), 8'h00);
`ifdef UART_RX_FRAMING_ERR_EN
    checkOutput("reset_frame_err", 8'(bus.frame_err), 8'h00);
`endif
    rst = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] single byte 45 with exact latency");
    applyStimulus(8'h45, 1'b1);
    @(negedge clk);
    checkOutput("t1_ready_edge21", 8'(bus.data_ready), 8'h00);
    @(negedge clk);
    checkOutput("t1_ready_edge22", 8'(bus.data_ready), 8'h01);
    checkOutput("t1_data", bus.data, 8'h45);
    readPulse();
    checkOutput("t1_read_clears", 8'(bus.data_ready), 8'h00);
    readPulse();
    checkOutput("t1_idle_read_ready", 8'(bus.data_ready), 8'h00);
    checkOutput("t1_idle_read_data", bus.data, 8'h45);
    repeat (4) @(negedge clk);

    $display("[TB] back-to-back 45, 4E overrun");
    applyStimulus(8'h45, 1'b1);
    applyStimulus(8'h4E, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("t2_data", bus.data, 8'h4E);
    checkOutput("t2_ready", 8'(bus.data_ready), 8'h01);
    readPulse();
    checkOutput("t2_read_clears", 8'(bus.data_ready), 8'h00);
    repeat (4) @(negedge clk);

    $display("[TB] glitch then A5");
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("t3_glitch_ready", 8'(bus.data_ready), 8'h00);
    checkOutput("t3_glitch_data", bus.data, 8'h4E);
    applyStimulus(8'hA5, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("t3_data", bus.data, 8'hA5);
    checkOutput("t3_ready", 8'(bus.data_ready), 8'h01);
    readPulse();
    checkOutput("t3_read_clears", 8'(bus.data_ready), 8'h00);
    repeat (4) @(negedge clk);

    $display("[TB] bad stop bit on 3C then held-low line");
    applyStimulus(8'h3C, 1'b0);
    repeat (2) @(negedge clk);
`ifdef UART_RX_FRAMING_ERR_EN
    checkOutput("t4_frame_err", 8'(bus.frame_err), 8'h01);
    checkOutput("t4_ready", 8'(bus.data_ready), 8'h00);
    checkOutput("t4_data_kept", bus.data, 8'hA5);
`else
    checkOutput("t4_data", bus.data, 8'h3C);
    checkOutput("t4_ready", 8'(bus.data_ready), 8'h01);
`endif
    readPulse();
    repeat (24) @(negedge clk);
    checkOutput("t4_hold_ready", 8'(bus.data_ready), 8'h00);
`ifdef UART_RX_FRAMING_ERR_EN
    checkOutput("t4_hold_data", bus.data, 8'hA5);
`else
    checkOutput("t4_hold_data", bus.data, 8'h3C);
`endif
    rx = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("t4_release_ready", 8'(bus.data_ready), 8'h00);

    $display("[TB] async reset mid-frame then 81");
    applyStimulus(8'h5A, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("t5_pre_data", bus.data, 8'h5A);
    checkOutput("t5_pre_ready", 8'(bus.data_ready), 8'h01);
    partial = 5'b11110;
    for (int i = 0; i < 5; i++) begin
      rx = partial[i];
      repeat (BIT_TIME) @(negedge clk);
    end
    #2 rst = 1'b0;
    #1;
    checkOutput("t5_async_data", bus.data, 8'h00);
    checkOutput("t5_async_ready", 8'(bus.data_ready), 8'h00);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(8'h81, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("t5_data", bus.data, 8'h81);
    checkOutput("t5_ready", 8'(bus.data_ready), 8'h01);
    repeat (4) @(negedge clk);

    $display("[TB] read collides with 7F completion");
    applyStimulus(8'h7F, 1'b1);
    @(negedge clk);
    checkOutput("t6_pre_data", bus.data, 8'h81);
    bus.data_read = 1'b1;
    @(negedge clk);
    bus.data_read = 1'b0;
    checkOutput("t6_data", bus.data, 8'h7F);
    checkOutput("t6_ready", 8'(bus.data_ready), 8'h01);
    @(negedge clk);
    checkOutput("t6_ready_holds", 8'(bus.data_ready), 8'h01);
    readPulse();
    checkOutput("t6_read_clears", 8'(bus.data_ready), 8'h00);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
